oam_line_scheduler: RTL and testbench
=====================================

# oam_line_scheduler

Sequences sprite line preparation and arbitrates the single OAM RAM port between the `prepare_line` sprite evaluator and CPU-side OAM writes. On each horizontal-blank entry it starts preparation of the next visible scanline and gives the evaluator exclusive read ownership of OAM until it reports `line_prepeared`. CPU writes that arrive meanwhile are queued and drained into OAM outside the prepare window. It sits between the bus interface, the OAM RAM and `prepare_line` in the video pipeline.

## Interface
- `H_ACTIVE`, 640: visible pixels per line; also the sx value that triggers preparation
- `V_ACTIVE`, 480: visible lines
- `V_TOTAL`, 525: total lines per frame
- `OAM_ADDR_W`, 6: OAM address width (64 entries)
- `OAM_DATA_W`, 32: OAM entry width
- `FIFO_DEPTH`, 4: CPU write queue depth (power of two)
- `PREP_TIMEOUT`, 150: maximum cycles allowed in PREP

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `sx` in 10: current pixel x
- `sy` in 10: current line y
- `cpu_wr_valid` in 1: CPU write request
- `cpu_wr_ready` out 1: queue can accept
- `cpu_wr_addr` in OAM_ADDR_W: write address
- `cpu_wr_data` in OAM_DATA_W: write data
- `prep_start` out 1: one-cycle start pulse to `prepare_line`
- `prep_line` out 10: line number to prepare
- `prep_oam_addr` in OAM_ADDR_W: read address from `prepare_line`
- `prep_done` in 1: `line_prepeared` from `prepare_line`
- `oam_addr` out OAM_ADDR_W: OAM RAM address
- `oam_we` out 1: OAM write enable
- `oam_wdata` out OAM_DATA_W: OAM write data
- `overrun` out 1: sticky; preparation timed out
- `overrun_clr` in 1: clears `overrun`

## Operation
- FSM states: IDLE, PREP.
- Trigger: `sx == H_ACTIVE` and registered previous `sx != H_ACTIVE`. This edge detection makes a held sx produce one trigger.
- Next line: `sy == V_TOTAL-1` gives 0; otherwise `sy+1`. Trigger is acted on only if next line < V_ACTIVE; otherwise it is ignored and there is no state change.
- IDLE -> PREP on an accepted trigger. In that cycle, register `prep_line` = next line, pulse `prep_start`, and clear the timeout counter.
- PREP -> IDLE on `prep_done`. Alternatively, when the timeout counter reaches PREP_TIMEOUT-1: set `overrun` and return to IDLE.
- Trigger while in PREP: set `overrun` and restart PREP for the new line (new `prep_start`).
- OAM port in PREP: `oam_addr = prep_oam_addr` (combinational pass-through), `oam_we = 0`.
- OAM port in IDLE: if the queue is non-empty, pop the head and drive a registered write (`oam_we=1`, addr/data = head) for one cycle per entry; otherwise `oam_we=0` and `oam_addr` holds its last value.
- A pop is suppressed in the cycle an IDLE->PREP transition is taken (start wins).
- Queue: `cpu_wr_ready = !full`. Push on `cpu_wr_valid && cpu_wr_ready`. Push and pop in the same cycle are both performed. Writes are applied in arrival order.
- `overrun_clr` clears `overrun`; a simultaneous set wins.

## Timing
- Reset (async assert, sync release): state IDLE, queue empty, `cpu_wr_ready=1`, `prep_start=0`, `prep_line=0`, `oam_we=0`, `oam_addr=0`, `oam_wdata=0`, `overrun=0`, `sx` history = 0.
- `prep_start` is asserted the cycle after the trigger edge cycle.
- `oam_we` for a queued write is asserted at the earliest in the cycle after the push (one-cycle latency in IDLE).
- After `prep_done`, the first queued write appears on `oam_we` in the next cycle.
- Reset mid-PREP aborts with no `prep_start` replay and discards queued writes.
- The pointer counter is wide enough for full/empty distinction (log2(FIFO_DEPTH)+1 bits); wrap-around is modulo depth.

## Structure
- Shared package `madnes_video_pkg` holds:
  - H_ACTIVE, V_ACTIVE, V_TOTAL, OAM_ADDR_W, OAM_DATA_W
  - `oam_entry_t` (32-bit sprite entry)
  - `oam_wr_t` (addr+data struct)
  - `sched_state_t` enum (IDLE, PREP)
- Sub-module `oam_wr_fifo`: synchronous FIFO of `oam_wr_t`, FIFO_DEPTH entries, full/empty, async active-low reset.

## Test plan
- Reset then `sy=15`, sx steps 639->640 -> `prep_start` pulses once next cycle, `prep_line=16`; `prep_done` after 40 cycles -> state IDLE.
- `sy=524`, sx reaches 640 -> `prep_line=0`. `sy=479` -> no `prep_start` (next line 480 not visible).
- 3 CPU writes (addr 5,6,7, data 0xA5A50001..3) during PREP -> no `oam_we` until `prep_done`, then 3 consecutive `oam_we` cycles in order.
- 5 back-to-back writes during PREP -> `cpu_wr_ready` low after 4th accepted; 5th held until first drain cycle, no data lost.
- No `prep_done` for 150 cycles -> `overrun=1`, IDLE; `overrun_clr` -> `overrun=0`.
- sx held at 640 for 4 cycles -> exactly one `prep_start`; `reset` asserted mid-PREP -> all outputs at reset values immediately.

Source files
------------

// File: rtl/madnes_video_pkg.sv
// Shared video timing constants and OAM types for the madnes video pipeline.
package madnes_video_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int V_TOTAL    = 525;
  localparam int OAM_ADDR_W = 6;
  localparam int OAM_DATA_W = 32;

  typedef logic [OAM_DATA_W-1:0] oam_entry_t;

  typedef struct packed {
    logic [OAM_ADDR_W-1:0] addr;
    oam_entry_t            data;
  } oam_wr_t;

  typedef enum logic {
    IDLE = 1'b0,
    PREP = 1'b1
  } sched_state_t;

endpackage

// File: rtl/oam_wr_fifo.sv
// Small synchronous FIFO holding CPU OAM writes until the OAM port is free.
module oam_wr_fifo
  import madnes_video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  oam_wr_t wr_i,
  input  logic    pop_i,
  output oam_wr_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wp_q, rp_q;
  oam_wr_t     mem_q [DEPTH];

  // Extra pointer bit tells full from empty when the indices match.
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[PW] != rp_q[PW]) &&
                   (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign head_o  = mem_q[rp_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wp_q[PW-1:0]] <= wr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wp_q <= wp_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rp_q <= rp_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/oam_line_scheduler.sv
// Starts sprite line preparation at hblank and arbitrates the OAM port
// between the line evaluator and queued CPU writes.
module oam_line_scheduler
  import madnes_video_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int PREP_TIMEOUT = 150
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            sx,
  input  logic [9:0]            sy,
  input  logic                  cpu_wr_valid,
  output logic                  cpu_wr_ready,
  input  logic [OAM_ADDR_W-1:0] cpu_wr_addr,
  input  logic [OAM_DATA_W-1:0] cpu_wr_data,
  output logic                  prep_start,
  output logic [9:0]            prep_line,
  input  logic [OAM_ADDR_W-1:0] prep_oam_addr,
  input  logic                  prep_done,
  output logic [OAM_ADDR_W-1:0] oam_addr,
  output logic                  oam_we,
  output logic [OAM_DATA_W-1:0] oam_wdata,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int CW = $clog2(PREP_TIMEOUT);

  sched_state_t          state_q;
  logic [9:0]            sx_q;
  logic [9:0]            prep_line_q;
  logic                  prep_start_q;
  logic [CW-1:0]         cnt_q;
  logic                  overrun_q;
  logic                  oam_we_q;
  logic [OAM_ADDR_W-1:0] oam_addr_q;
  logic [OAM_DATA_W-1:0] oam_wdata_q;

  logic       trig, accept, timeout, go_idle;
  logic       push, pop, full, empty;
  logic [9:0] nxt_line;
  oam_wr_t    head, wr;

  assign trig     = (sx == 10'(H_ACTIVE)) && (sx_q != 10'(H_ACTIVE));
  assign nxt_line = (sy == 10'(V_TOTAL-1)) ? '0 : sy + 10'd1;
  assign accept   = trig && (nxt_line < 10'(V_ACTIVE));
  assign timeout  = (state_q == PREP) && !prep_done &&
                    (cnt_q == CW'(PREP_TIMEOUT-1));
  // Writes may drain in any cycle whose next state is IDLE.
  assign go_idle  = !accept &&
                    ((state_q == IDLE) || prep_done || timeout);
  assign pop      = go_idle && !empty;
  assign push     = cpu_wr_valid && !full;
  assign wr       = '{addr: cpu_wr_addr, data: cpu_wr_data};

  oam_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (push),
    .wr_i   (wr),
    .pop_i  (pop),
    .head_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sx_q         <= '0;
      prep_line_q  <= '0;
      prep_start_q <= 1'b0;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      oam_we_q     <= 1'b0;
      oam_addr_q   <= '0;
      oam_wdata_q  <= '0;
    end else begin
      sx_q         <= sx;
      prep_start_q <= 1'b0;
      oam_we_q     <= pop;
      if (pop) begin
        oam_addr_q  <= head.addr;
        oam_wdata_q <= head.data;
      end
      if (accept) begin
        state_q      <= PREP;
        prep_line_q  <= nxt_line;
        prep_start_q <= 1'b1;
        cnt_q        <= '0;
      end else if (go_idle) begin
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((accept && state_q == PREP) || timeout) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign cpu_wr_ready = !full;
  assign prep_start   = prep_start_q;
  assign prep_line    = prep_line_q;
  assign oam_addr     = (state_q == PREP) ? prep_oam_addr : oam_addr_q;
  assign oam_we       = oam_we_q;
  assign oam_wdata    = oam_wdata_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_oam_line_scheduler.sv
// Directed and random checks of oam_line_scheduler against a queue model.
module tb_oam_line_scheduler;
  import madnes_video_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  sx = '0;
  logic [9:0]  sy = '0;
  logic        cpu_wr_valid = 1'b0;
  logic        cpu_wr_ready;
  logic [5:0]  cpu_wr_addr = '0;
  logic [31:0] cpu_wr_data = '0;
  logic        prep_start;
  logic [9:0]  prep_line;
  logic [5:0]  prep_oam_addr = 6'h2a;
  logic        prep_done = 1'b0;
  logic [5:0]  oam_addr;
  logic        oam_we;
  logic [31:0] oam_wdata;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  oam_line_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .sx           (sx),
    .sy           (sy),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .prep_start   (prep_start),
    .prep_line    (prep_line),
    .prep_oam_addr(prep_oam_addr),
    .prep_done    (prep_done),
    .oam_addr     (oam_addr),
    .oam_we       (oam_we),
    .oam_wdata    (oam_wdata),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a busy flag with a start timestamp and a write queue.
  bit          m_prep, m_start, m_we, m_ovr;
  logic [9:0]  m_line, m_sxp;
  logic [5:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cyc = 0;
  int          m_t0 = 0;
  logic [37:0] m_q[$];

  task automatic model_step();
    bit   acc, set, rdy;
    int   nl;
    logic [37:0] w;
    m_cyc++;
    if (!reset) begin
      m_prep = 0; m_start = 0; m_we = 0; m_ovr = 0;
      m_line = '0; m_sxp = '0; m_waddr = '0; m_wdata = '0;
      m_q.delete();
      return;
    end
    nl  = (int'(sy) == V_TOTAL - 1) ? 0 : int'(sy) + 1;
    acc = (int'(sx) == H_ACTIVE) && (int'(m_sxp) != H_ACTIVE) &&
          (nl < V_ACTIVE);
    set = 0;
    m_start = 0;
    rdy = (m_q.size() < 4);
    if (acc) begin
      if (m_prep) set = 1;
      m_prep  = 1;
      m_line  = 10'(nl);
      m_start = 1;
      m_t0    = m_cyc;
    end else if (m_prep) begin
      if (prep_done) m_prep = 0;
      else if (m_cyc - m_t0 == 150) begin
        set = 1;
        m_prep = 0;
      end
    end
    m_we = 0;
    if (!m_prep && m_q.size() > 0) begin
      w = m_q.pop_front();
      m_we = 1;
      m_waddr = w[37:32];
      m_wdata = w[31:0];
    end
    if (cpu_wr_valid && rdy) m_q.push_back({cpu_wr_addr, cpu_wr_data});
    if (set) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    m_sxp = sx;
  endtask

  task automatic compare_all();
    chk("start", 64'(prep_start), 64'(m_start));
    chk("line", 64'(prep_line), 64'(m_line));
    chk("we", 64'(oam_we), 64'(m_we));
    chk("addr", 64'(oam_addr), 64'(m_prep ? prep_oam_addr : m_waddr));
    chk("wdata", 64'(oam_wdata), 64'(m_wdata));
    chk("ready", 64'(cpu_wr_ready), 64'(m_q.size() < 4));
    chk("ovr", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic trigger(input logic [9:0] y);
    sy = y;
    sx = 10'd639;
    step();
    sx = 10'd640;
    step();
    sx = 10'd0;
  endtask

  initial begin
    int starts;
    int waits;
    bit acc;
    step();
    step();
    chk("rst_ready", 64'(cpu_wr_ready), 64'd1);
    chk("rst_we", 64'(oam_we), 64'd0);
    reset = 1'b1;
    step();

    trigger(10'd15);
    chk("t1_start", 64'(prep_start), 64'd1);
    chk("t1_line", 64'(prep_line), 64'd16);
    for (int i = 0; i < 3; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 6'(5 + i);
      cpu_wr_data  = 32'hA5A50001 + 32'(i);
      step();
    end
    cpu_wr_valid = 1'b0;
    repeat (36) step();
    chk("t1_nowe", 64'(oam_we), 64'd0);
    prep_done = 1'b1;
    step();
    prep_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_we", 64'(oam_we), 64'd1);
      chk("drain_addr", 64'(oam_addr), 64'(5 + i));
      chk("drain_data", 64'(oam_wdata), 64'(32'hA5A50001 + 32'(i)));
      step();
    end
    chk("drain_end", 64'(oam_we), 64'd0);

    trigger(10'd524);
    chk("wrap_line", 64'(prep_line), 64'd0);
    prep_done = 1'b1;
    step();
    prep_done = 1'b0;
    trigger(10'd479);
    chk("invis_start", 64'(prep_start), 64'd0);
    step();

    trigger(10'd100);
    waits = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 6'(20 + i);
      cpu_wr_data  = $urandom;
      acc = 1'b0;
      while (!acc && waits < 60) begin
        acc = cpu_wr_ready;
        prep_done = (waits >= 12);
        step();
        waits++;
      end
      if (!acc) chk("wr_accept", 64'(acc), 64'd1);
      if (i == 3) chk("full_ready", 64'(cpu_wr_ready), 64'd0);
    end
    cpu_wr_valid = 1'b0;
    prep_done = 1'b0;
    repeat (8) step();

    trigger(10'd200);
    repeat (155) step();
    chk("to_ovr", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("clr_ovr", 64'(overrun), 64'd0);

    sy = 10'd50;
    sx = 10'd639;
    step();
    sx = 10'd640;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      starts += int'(prep_start);
    end
    chk("held_sx", 64'(starts), 64'd1);
    cpu_wr_valid = 1'b1;
    step();
    cpu_wr_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("ar_start", 64'(prep_start), 64'd0);
    chk("ar_line", 64'(prep_line), 64'd0);
    chk("ar_addr", 64'(oam_addr), 64'd0);
    chk("ar_ready", 64'(cpu_wr_ready), 64'd1);
    step();
    reset = 1'b1;
    sx = 10'd0;
    repeat (3) step();

    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 19))
        0, 1, 2: sx = 10'd640;
        3:       sx = 10'd639;
        default: sx = 10'($urandom_range(0, 1023));
      endcase
      case ($urandom_range(0, 7))
        0:       sy = 10'd479;
        1:       sy = 10'd524;
        2:       sy = 10'd523;
        3:       sy = 10'd478;
        default: sy = 10'($urandom_range(0, 523));
      endcase
      prep_done     = ($urandom_range(0, 59) == 0);
      cpu_wr_valid  = $urandom_range(0, 1) == 1;
      cpu_wr_addr   = 6'($urandom);
      cpu_wr_data   = $urandom;
      prep_oam_addr = 6'($urandom);
      overrun_clr   = ($urandom_range(0, 15) == 0);
      reset         = ($urandom_range(0, 799) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
